// File: rtl/instruction_fetch.sv
// Fetch stage of the 5-stage MIPS pipeline: PC register, loader-written instruction
// memory and the IF/ID register. A LOAD -> RUN -> DONE FSM; DONE is entered on HALT.
module instruction_fetch #(
    parameter int NB_DATA   = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic               i_jump,
    input  logic [NB_DATA-1:0] i_addr2jump,
    input  logic               i_we_mem,
    input  logic [NB_DATA-1:0] i_wr_addr_mem,
    input  logic [NB_DATA-1:0] i_wr_data_mem,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_DATA-1:0] o_pcounter4,
    output logic [NB_DATA-1:0] o_pc,
    output logic               o_running,
    output logic               o_done
);

    localparam int NB_ADDR = $clog2(MEM_DEPTH);
    localparam logic [NB_DATA-1:0] HALT_WORD = {NB_DATA{1'b1}};
    localparam logic [NB_DATA-1:0] NOP_WORD  = '0;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [NB_DATA-1:0] pc;
    logic [NB_DATA-1:0] pc_plus4;
    logic [NB_DATA-1:0] fetch_word;
    logic [NB_ADDR-1:0] rd_idx;
    logic [NB_ADDR-1:0] wr_idx;
    logic [NB_DATA-1:0] mem [MEM_DEPTH];

    // Word index only; byte offset and upper address bits wrap modulo depth.
    assign rd_idx     = pc[NB_ADDR+1:2];
    assign wr_idx     = i_wr_addr_mem[NB_ADDR+1:2];
    assign fetch_word = mem[rd_idx];
    assign pc_plus4   = pc + NB_DATA'(4);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_wr_addr_mem[NB_DATA-1:NB_ADDR+2],
                                i_wr_addr_mem[1:0], i_addr2jump[1:0]};

    // Memory has no reset so a reset mid-run keeps the loaded program.
    always_ff @(posedge clk) begin
        if (!i_rst && state == ST_LOAD && i_we_mem) begin
            mem[wr_idx] <= i_wr_data_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state         <= ST_LOAD;
            pc            <= '0;
            o_instruction <= NOP_WORD;
            o_pcounter4   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    pc            <= '0;
                    o_instruction <= NOP_WORD;
                    o_pcounter4   <= '0;
                    if (i_start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_halt || i_stall) begin
                        pc            <= pc;
                    end else if (i_jump) begin
                        // One-bubble flush; the redirected word arrives next edge.
                        pc            <= {i_addr2jump[NB_DATA-1:2], 2'b00};
                        o_instruction <= NOP_WORD;
                        o_pcounter4   <= '0;
                    end else begin
                        o_instruction <= fetch_word;
                        o_pcounter4   <= pc_plus4;
                        pc            <= pc_plus4;
                        if (fetch_word == HALT_WORD) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    o_instruction <= NOP_WORD;
                    o_pcounter4   <= '0;
                end
            endcase
        end
    end

    assign o_pc      = pc;
    assign o_running = (state == ST_RUN);
    assign o_done    = (state == ST_DONE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch: each row drives one clock
// edge and lists the IF/ID, PC and state flags expected right after it.
module tb_instruction_fetch;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_stall;
    logic        i_halt;
    logic        i_jump;
    logic [31:0] i_addr2jump;
    logic        i_we_mem;
    logic [31:0] i_wr_addr_mem;
    logic [31:0] i_wr_data_mem;
    logic [31:0] o_instruction;
    logic [31:0] o_pcounter4;
    logic [31:0] o_pc;
    logic        o_running;
    logic        o_done;

    instruction_fetch #(.NB_DATA(32), .MEM_DEPTH(256)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_stall      (i_stall),
        .i_halt       (i_halt),
        .i_jump       (i_jump),
        .i_addr2jump  (i_addr2jump),
        .i_we_mem     (i_we_mem),
        .i_wr_addr_mem(i_wr_addr_mem),
        .i_wr_data_mem(i_wr_data_mem),
        .o_instruction(o_instruction),
        .o_pcounter4  (o_pcounter4),
        .o_pc         (o_pc),
        .o_running    (o_running),
        .o_done       (o_done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start, stall, halt, jump;
        logic [31:0] jaddr;
        logic        we;
        logic [31:0] waddr, wdata;
        logic [31:0] ei, ep4, epc;
        logic        er, ed;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t v(input logic rst, start, stall, halt, jump,
                               input logic [31:0] jaddr, input logic we,
                               input logic [31:0] waddr, wdata, ei, ep4, epc,
                               input logic er, ed);
        vec_t t;
        t.rst = rst; t.start = start; t.stall = stall; t.halt = halt; t.jump = jump;
        t.jaddr = jaddr; t.we = we; t.waddr = waddr; t.wdata = wdata;
        t.ei = ei; t.ep4 = ep4; t.epc = epc; t.er = er; t.ed = ed;
        return t;
    endfunction

    // Scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Driver: apply one row, clock it, compare 1 time unit after the edge.
    task automatic apply(input vec_t t, input string tag);
        i_rst = t.rst; i_start = t.start; i_stall = t.stall; i_halt = t.halt;
        i_jump = t.jump; i_addr2jump = t.jaddr; i_we_mem = t.we;
        i_wr_addr_mem = t.waddr; i_wr_data_mem = t.wdata;
        @(posedge clk);
        #1;
        chk({tag, " instr"},   o_instruction,        t.ei);
        chk({tag, " pc4"},     o_pcounter4,          t.ep4);
        chk({tag, " pc"},      o_pc,                 t.epc);
        chk({tag, " running"}, {31'b0, o_running},   {31'b0, t.er});
        chk({tag, " done"},    {31'b0, o_done},      {31'b0, t.ed});
    endtask

    localparam logic [31:0] I0 = 32'h2001_0005;
    localparam logic [31:0] I1 = 32'h2002_0003;
    localparam logic [31:0] HW = 32'hFFFF_FFFF;
    localparam logic [31:0] I7 = 32'h1111_1117;
    localparam logic [31:0] BD = 32'h0BAD_0BAD;

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_halt = 1'b0; i_jump = 1'b0;
        i_addr2jump = '0; i_we_mem = 1'b0; i_wr_addr_mem = '0; i_wr_data_mem = '0;

        //                rst st sl hl jp jaddr   we waddr   wdata  ei  ep4    epc    r  d
        vecs.push_back(v(1, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, 0,  0,     0,     0, 0)); // reset
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  1, 32'h0,  I0,    0,  0,     0,     0, 0)); // load
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  1, 32'h4,  I1,    0,  0,     0,     0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  1, 32'h8,  HW,    0,  0,     0,     0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  1, 32'h1C, I7,    0,  0,     0,     0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 32'h0,  1, 32'h0,  BD,    0,  0,     0,     0, 0)); // reset drops write
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h40, 0, 32'h0,  32'h0, 0,  0,     0,     0, 0)); // LOAD ignores reqs
        vecs.push_back(v(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, 0,  0,     0,     1, 0)); // start
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, I0, 32'h4, 32'h4, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 32'h0,  0, 32'h0,  32'h0, I0, 32'h4, 32'h4, 1, 0)); // stall x2
        vecs.push_back(v(0, 0, 1, 0, 0, 32'h0,  0, 32'h0,  32'h0, I0, 32'h4, 32'h4, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0, I0, 32'h4, 32'h4, 1, 0)); // halt x3
        vecs.push_back(v(0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0, I0, 32'h4, 32'h4, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0, I0, 32'h4, 32'h4, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, I1, 32'h8, 32'h8, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 1, 32'h1E, 0, 32'h0,  32'h0, I1, 32'h8, 32'h8, 1, 0)); // stall beats jump
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h1E, 0, 32'h0,  32'h0, 0,  0,     32'h1C, 1, 0)); // jump flush
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  1, 32'h0,  BD,    I7, 32'h20, 32'h20, 1, 0)); // RUN write ignored
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h10, 0, 32'h0,  32'h0, 0,  0,     32'h10, 1, 0)); // to PC=0x10
        vecs.push_back(v(1, 0, 0, 0, 0, 32'h0,  1, 32'h0,  BD,    0,  0,     0,     0, 0)); // reset mid-run
        vecs.push_back(v(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, 0,  0,     0,     1, 0)); // restart
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, I0, 32'h4, 32'h4, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, I1, 32'h8, 32'h8, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, HW, 32'hC, 32'hC, 0, 1)); // HALT fetched
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, 0,  0,     32'hC, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 1, 32'h40, 1, 32'h0,  BD,    0,  0,     32'hC, 0, 1)); // DONE ignores all
        vecs.push_back(v(1, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, 0,  0,     0,     0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  1, 32'h400, 32'hDEADBEEF, 0, 0, 0,  0, 0)); // wraps to mem[0]
        vecs.push_back(v(0, 1, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, 0,  0,     0,     1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0, 32'hDEADBEEF, 32'h4, 32'h4, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Hand-written: halt toggled every cycle must neither drop nor repeat a word.
        apply(v(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h4, 32'h4, 1, 0), "tog0");
        apply(v(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, I1, 32'h8, 32'h8, 1, 0), "tog1");
        apply(v(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0, I1, 32'h8, 32'h8, 1, 0), "tog2");
        apply(v(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, HW, 32'hC, 32'hC, 0, 1), "tog3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front stage of the 5-stage MIPS pipeline: holds the program counter and a word-organised instruction memory, and drives the IF/ID register (`o_instruction`, `o_pcounter4`) into the decode stage. It consumes the decode stage's jump/branch resolution (`i_jump`, `i_addr2jump`), the hazard unit's stall and the debug unit's halt. In the loading phase, the debug loader writes the program word by word. Fetch is then started, and it stops on its own when it fetches the HALT word.

## Interface
- `NB_DATA`, 32, instruction/PC/data width
- `MEM_DEPTH`, 256, instruction memory depth in words (power of two)
- `clk`  in  1  clock, all state on rising edge
- `i_rst`  in  1  synchronous reset, active-high
- `i_start`  in  1  leave LOAD and begin fetching at PC 0
- `i_stall`  in  1  load-use stall from hazard unit; hold PC and IF/ID
- `i_halt`  in  1  debug freeze; hold PC and IF/ID
- `i_jump`  in  1  redirect request from decode (combinational, same cycle)
- `i_addr2jump`  in  NB_DATA  redirect target byte address
- `i_we_mem`  in  1  loader write strobe
- `i_wr_addr_mem`  in  NB_DATA  loader byte address
- `i_wr_data_mem`  in  NB_DATA  loader word
- `o_instruction`  out  NB_DATA  IF/ID instruction
- `o_pcounter4`  out  NB_DATA  IF/ID PC+4 of `o_instruction`
- `o_pc`  out  NB_DATA  current PC register (debug)
- `o_running`  out  1  state == RUN
- `o_done`  out  1  state == DONE

## Operation
- State machine, 3 states. LOAD is entered on reset.
  - LOAD → RUN on `i_start`.
  - RUN → DONE when HALT is fetched.
  - DONE exits only on reset.
- Memory: `MEM_DEPTH` × `NB_DATA`, synchronous write, asynchronous read. Index is byte address bits `[log2(MEM_DEPTH)+1:2]`; upper bits and bits `[1:0]` are ignored, so indexing wraps modulo depth. Contents are not affected by reset.
- Writes are accepted only in LOAD. `i_we_mem` in RUN or DONE is ignored.
- LOAD: PC = 0; IF/ID holds NOP (`32'h0`); `i_stall`, `i_halt` and `i_jump` are ignored.
- RUN, per cycle, evaluated in priority order:
  1. `i_halt` or `i_stall`: PC, `o_instruction` and `o_pcounter4` hold.
  2. `i_jump`: PC ← `{i_addr2jump[NB_DATA-1:2],2'b00}`; `o_instruction` ← NOP (one-bubble flush, no delay slot); `o_pcounter4` ← 0.
  3. Otherwise: `o_instruction` ← mem[PC]; `o_pcounter4` ← PC+4; PC ← PC+4, mod 2^NB_DATA.
- HALT: when case 3 fetches `32'hFFFFFFFF`, that word is still registered into IF/ID, and the state goes to DONE with PC frozen.
- DONE: `o_instruction` ← NOP, `o_pcounter4` ← 0, PC frozen, all requests ignored.
- `i_start` is ignored outside LOAD.

## Timing
- Reset values (next edge with `i_rst`=1, any state):
  - PC = 0
  - `o_instruction` = 0
  - `o_pcounter4` = 0
  - `o_running` = 0
  - `o_done` = 0
  - state LOAD
- Reset has priority over everything: a `i_we_mem` write in a reset cycle is discarded. Reset mid-RUN abandons fetch; memory contents are retained.
- Fetch latency: 1 cycle. A word at PC appears on `o_instruction` the edge after it is addressed.
- `i_start` at edge N: RUN from N. The first fetch (mem[0]) is registered at edge N+1.
- Jump: `i_jump` sampled at edge N. NOP is on IF/ID after N, and mem[target] appears after N+1.
- `i_stall` together with `i_jump`: stall wins. Decode sees the same instruction again and re-asserts the jump next cycle.
- `i_halt` released: fetch resumes on the same edge with no lost or duplicated instruction.
- Loader write at edge N is readable by fetch from edge N+1.
- `o_running`/`o_done` are decoded from registered state (no combinational path from inputs).

## Test plan
- Load, start, sequence: load 0x20010005, 0x20020003, 0xFFFFFFFF at byte addresses 0, 4, 8, then pulse `i_start`. Required response:
  - IF/ID shows (0x20010005, 4), then (0x20020003, 8), then (0xFFFFFFFF, 12).
  - Then NOP with `o_done`=1 and `o_pc`=12 frozen.
- Jump flush: in RUN at PC=8, assert `i_jump` with `i_addr2jump`=0x0000001E. Required response:
  - Next IF/ID = (0, 0).
  - `o_pc`=0x1C, then IF/ID = (mem[7], 0x20).
- Stall and halt hold: assert `i_stall` for 2 cycles, then `i_halt` for 3 cycles, mid-sequence. Required response:
  - IF/ID and `o_pc` are unchanged throughout.
  - The next instruction follows with no gaps or duplicates.
- Stall + jump same cycle: assert both. Required response: state held. Then deassert stall while keeping jump; the redirect occurs exactly once.
- Write protection and wrap: with `MEM_DEPTH`=256, write in RUN to address 0. Required response: mem[0] is unchanged. Separately, in LOAD write 0xDEADBEEF at byte address 0x400; fetch at PC 0 returns 0xDEADBEEF.
- Reset mid-run: assert `i_rst` in RUN at PC=0x10 while `i_we_mem` is high. Required response:
  - All outputs read 0 and state is LOAD.
  - The write is discarded; the program is intact.
  - Restarting reproduces the first scenario's sequence.
